// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its prefetch FIFO.
package fetch_pkg;

   localparam int          FETCH_ADDR_W     = 16;
   localparam int          FETCH_INSTR_W    = 32;
   localparam logic [1:0]  IMEM_TYPE_SINGLE = 2'b00;
   localparam logic [31:0] HALT_WORD_DFLT   = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } fetch_state_t;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0]  pc;
      logic [FETCH_INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with a registered head; flush beats push, push allowed when full if popping.
// Latency: a pushed entry is visible at the head the next cycle (no bypass); head holds its last value when empty.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = fetch_entry_t,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  entry_t           push_dat,
   input  logic             pop,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output entry_t           head_dat,
   output logic             head_vld
);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr_nxt;
   logic [CNT_W-1:0] remain;
   logic [CNT_W-1:0] count_nxt;
   logic             pop_eff;
   logic             push_eff;

   always_comb begin
      pop_eff    = pop && (count != '0);
      push_eff   = push && ((count != CNT_W'(DEPTH)) || pop_eff);
      remain     = count - CNT_W'(pop_eff);
      count_nxt  = remain + CNT_W'(push_eff);
      rd_ptr_nxt = rd_ptr + PTR_W'(pop_eff);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         head_dat <= '0;
         head_vld <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         head_vld <= 1'b0;
      end else begin
         if (push_eff) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         rd_ptr   <= rd_ptr_nxt;
         count    <= count_nxt;
         head_vld <= (count_nxt != '0);
         // Next head is the incoming word only when nothing older survives this cycle.
         if (count_nxt != '0) begin
            head_dat <= (remain == '0) ? push_dat : mem[rd_ptr_nxt];
         end
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fetches one ROM word per cycle into a prefetch FIFO.
// Latency: first if_valid one cycle after the first RUN cycle; decode backpressure stalls fetch once the FIFO is full.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int                ADDR_W    = FETCH_ADDR_W,
   parameter int                INSTR_W   = FETCH_INSTR_W,
   parameter int                DEPTH     = 2,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DFLT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               fetch_en,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [1:0]         imem_opcode_type,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   input  logic               if_ready,
   output logic               halted
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   fetch_state_t     state;
   logic [ADDR_W-1:0] pc;
   logic [CNT_W-1:0] count;
   entry_t           push_dat;
   entry_t           head_dat;
   logic             pop;
   logic             room;
   logic             push;

   assign pop      = if_valid && if_ready;
   assign room     = (count < CNT_W'(DEPTH)) || pop;
   assign push     = (state == RUN) && fetch_en && !redirect_valid && room;

   assign push_dat.pc    = pc;
   assign push_dat.instr = imem_instr;

   assign imem_addr        = pc;
   assign imem_opcode_type = IMEM_TYPE_SINGLE;
   assign if_instr         = head_dat.instr;
   assign if_pc            = head_dat.pc;

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .flush    (redirect_valid),
      .count    (count),
      .head_dat (head_dat),
      .head_vld (if_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         halted <= 1'b0;
      end else if (redirect_valid) begin
         // A redirect is the only way out of HALT and wins over everything else.
         pc     <= redirect_pc;
         state  <= fetch_en ? RUN : IDLE;
         halted <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (fetch_en) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (!fetch_en) begin
                  state <= IDLE;
               end else if (push) begin
                  pc <= pc + ADDR_W'(1);
                  if (imem_instr == HALT_WORD) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: queue-based reference model compared every cycle, plus directed literal checks.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic [15:0] imem_addr;
   logic [1:0]  imem_opcode_type;
   logic [31:0] imem_instr;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [15:0] if_pc;
   logic        if_ready;
   logic        halted;
   logic        halt_en;

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .fetch_en         (fetch_en),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .imem_addr        (imem_addr),
      .imem_opcode_type (imem_opcode_type),
      .imem_instr       (imem_instr),
      .if_valid         (if_valid),
      .if_instr         (if_instr),
      .if_pc            (if_pc),
      .if_ready         (if_ready),
      .halted           (halted)
   );

   // ROM: word at address a is {~a, a}; address 5 holds the halt word when halt_en is set.
   always_comb begin
      imem_instr = (halt_en && imem_addr == 16'd5) ? 32'hFFFF_FFFF : {~imem_addr, imem_addr};
   end

   typedef struct packed {
      logic [15:0] pc;
      logic [31:0] instr;
   } m_ent_t;

   m_ent_t      m_q[$];
   m_ent_t      m_last;
   logic [15:0] m_pc;
   int          m_mode;
   logic        m_halted;
   logic        m_pop;
   logic [31:0] m_word;
   int          checks = 0;
   int          errors = 0;
   bit          arm = 0;

   function automatic logic [31:0] m_rom(input logic [15:0] a, input logic hen);
      if (hen && a == 16'd5) return 32'hFFFF_FFFF;
      return {~a, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 idle, 1 running, 2 halted.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_q.delete();
         m_pc     = 16'h0000;
         m_mode   = 0;
         m_halted = 1'b0;
         m_last   = '0;
      end else begin
         m_pop = (m_q.size() > 0) && if_ready;
         if (redirect_valid) begin
            m_q.delete();
            m_pc     = redirect_pc;
            m_mode   = fetch_en ? 1 : 0;
            m_halted = 1'b0;
         end else begin
            if (m_pop) void'(m_q.pop_front());
            if (m_mode == 1 && fetch_en) begin
               if (m_q.size() < 2) begin
                  m_word = m_rom(m_pc, halt_en);
                  m_q.push_back('{pc: m_pc, instr: m_word});
                  m_pc = m_pc + 16'd1;
                  if (m_word == 32'hFFFF_FFFF) begin
                     m_mode   = 2;
                     m_halted = 1'b1;
                  end
               end
            end else if (m_mode == 1) begin
               m_mode = 0;
            end else if (m_mode == 0 && fetch_en) begin
               m_mode = 1;
            end
         end
         if (m_q.size() > 0) m_last = m_q[0];
      end
   end

   initial forever begin
      @(negedge clk);
      if (arm) begin
         chk("cmp_valid", {31'd0, if_valid}, {31'd0, m_q.size() > 0});
         chk("cmp_pc", {16'd0, if_pc}, {16'd0, m_last.pc});
         chk("cmp_instr", if_instr, m_last.instr);
         chk("cmp_addr", {16'd0, imem_addr}, {16'd0, m_pc});
         chk("cmp_halted", {31'd0, halted}, {31'd0, m_halted});
         chk("cmp_optype", {30'd0, imem_opcode_type}, 32'd0);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n          = 1'b1;
      fetch_en       = 1'b1;
      if_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      halt_en        = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_pc", {16'd0, if_pc}, 32'd0);
      chk("rst_instr", if_instr, 32'd0);
      step(2);
      rst_n = 1'b1;
      arm   = 1'b1;

      // Streaming start
      step(1);
      chk("n1_valid", {31'd0, if_valid}, 32'd0);
      step(1);
      chk("n2_valid", {31'd0, if_valid}, 32'd1);
      chk("n2_pc", {16'd0, if_pc}, 32'h0000);
      chk("n2_instr", if_instr, 32'hFFFF_0000);
      step(1);
      chk("n3_instr", if_instr, 32'hFFFE_0001);
      step(2);
      chk("n5_pc", {16'd0, if_pc}, 32'h0003);
      if_ready = 1'b0;

      // Backpressure
      step(5);
      chk("bp_pc", {16'd0, if_pc}, 32'h0003);
      chk("bp_addr", {16'd0, imem_addr}, 32'h0005);
      if_ready = 1'b1;
      step(1);
      chk("rel_pc", {16'd0, if_pc}, 32'h0004);
      step(1);
      chk("rel_addr", {16'd0, imem_addr}, 32'h0007);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0100;

      // Redirect while full
      step(1);
      chk("rd_valid", {31'd0, if_valid}, 32'd0);
      chk("rd_hold_pc", {16'd0, if_pc}, 32'h0005);
      chk("rd_addr", {16'd0, imem_addr}, 32'h0100);
      redirect_valid = 1'b0;
      step(1);
      chk("rd_first_pc", {16'd0, if_pc}, 32'h0100);
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFE;

      // Wrap
      step(1);
      redirect_valid = 1'b0;
      step(1);
      chk("wr_fffe", {16'd0, if_pc}, 32'hFFFE);
      step(1);
      chk("wr_ffff", {16'd0, if_pc}, 32'hFFFF);
      step(1);
      chk("wr_0000", {16'd0, if_pc}, 32'h0000);
      chk("wr_instr", if_instr, 32'hFFFF_0000);
      step(1);
      chk("wr_0001", {16'd0, if_pc}, 32'h0001);
      halt_en        = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0000;

      // Halt
      step(1);
      redirect_valid = 1'b0;
      step(6);
      chk("ht_instr", if_instr, 32'hFFFF_FFFF);
      chk("ht_pc", {16'd0, if_pc}, 32'h0005);
      chk("ht_halted", {31'd0, halted}, 32'd1);
      chk("ht_addr", {16'd0, imem_addr}, 32'h0006);
      step(4);
      chk("ht_addr2", {16'd0, imem_addr}, 32'h0006);
      chk("ht_valid2", {31'd0, if_valid}, 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0010;
      step(1);
      chk("hr_halted", {31'd0, halted}, 32'd0);
      redirect_valid = 1'b0;
      step(1);
      chk("hr_pc", {16'd0, if_pc}, 32'h0010);
      fetch_en = 1'b0;

      // fetch_en gap
      step(3);
      chk("fe_addr", {16'd0, imem_addr}, 32'h0011);
      chk("fe_valid", {31'd0, if_valid}, 32'd0);
      chk("fe_hold", {16'd0, if_pc}, 32'h0010);
      fetch_en = 1'b1;
      step(2);
      chk("fe_resume", {16'd0, if_pc}, 32'h0011);
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0000;
      step(1);
      redirect_valid = 1'b0;
      if_ready       = 1'b0;

      // Halt reached with a backed-up FIFO, then async reset between edges
      step(9);
      chk("hf_halted", {31'd0, halted}, 32'd0);
      if_ready = 1'b1;
      step(6);
      chk("hf_halted2", {31'd0, halted}, 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", {31'd0, if_valid}, 32'd0);
      chk("ar_halted", {31'd0, halted}, 32'd0);
      chk("ar_addr", {16'd0, imem_addr}, 32'h0000);
      step(1);
      rst_n = 1'b1;
      step(2);
      chk("ar_restart", {31'd0, if_valid}, 32'd1);
      chk("ar_restart_pc", {16'd0, if_pc}, 32'h0000);
      step(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller in front of the instruction ROM.
- Owns the program counter and drives the ROM's 16-bit word address and 2-bit fetch-type select.
- Captures the combinationally returned 32-bit word into a small prefetch FIFO and hands instructions to decode over a valid/ready handshake.
- Handles branch redirects with flush, and a halt instruction that stops fetch.

Parameters:
- ADDR_W, 16, instruction word-address width; PC wraps modulo 2^ADDR_W.
- INSTR_W, 32, instruction width.
- DEPTH, 2, prefetch FIFO entries; power of two, >= 2.
- RESET_PC, 16'h0000, PC loaded at reset.
- HALT_WORD, 32'hFFFF_FFFF, encoding that halts fetch.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  level enable; 0 freezes fetch, FIFO contents kept.
- redirect_valid  in  1  one-cycle branch/jump request.
- redirect_pc  in  ADDR_W  target word address.
- imem_addr  out  ADDR_W  ROM word address (= pc register).
- imem_opcode_type  out  2  ROM fetch type; constant 2'b00, single-word fetch.
- imem_instr  in  INSTR_W  ROM data, combinational from imem_addr, same cycle.
- if_valid  out  1  FIFO head valid.
- if_instr  out  INSTR_W  FIFO head instruction.
- if_pc  out  ADDR_W  FIFO head address.
- if_ready  in  1  decode accepts the head this cycle.
- halted  out  1  fetch stopped by HALT_WORD.

Behaviour:
- **Reset (async assert, sync release):**
  - pc = RESET_PC; FIFO empty.
  - if_valid = 0; if_instr = 0; if_pc = 0; halted = 0; state = IDLE.
- **FSM states:** IDLE, RUN, HALT.
  - IDLE -> RUN when fetch_en = 1.
  - RUN -> IDLE when fetch_en = 0.
  - RUN -> HALT when a pushed word equals HALT_WORD.
  - HALT -> RUN only on redirect_valid, regardless of fetch_en; the redirect target then enters RUN if fetch_en = 1, else IDLE.
  - halted = 1 exactly in HALT.
- **Pop:** pop = if_valid && if_ready.
- **Push:** push = (state == RUN) && !redirect_valid && (count < DEPTH || pop).
  - Push writes {imem_addr, imem_instr} at the tail and sets pc <= pc + 1, wrapping 16'hFFFF -> 16'h0000.
  - No push leaves pc unchanged.
- **Throughput:** one instruction per cycle sustained when if_ready is held high.
- **Latency:** first if_valid is one cycle after the first RUN cycle. The head is registered; if_instr and if_pc do not depend combinationally on imem_instr.
- **Full FIFO with pop in the same cycle:** push is still allowed (simultaneous push and pop); count unchanged.
- **Empty FIFO:** no bypass; the pushed word becomes visible next cycle.
- **Redirect (highest priority, any state):**
  - FIFO is flushed; count = 0 and if_valid = 0 next cycle.
  - Any same-cycle pop is ignored for bookkeeping.
  - pc <= redirect_pc; no push that cycle; HALT is cleared.
- **Halt:**
  - The HALT_WORD itself is pushed and delivered to decode.
  - pc stays at the halt address + 1.
  - No further pushes; the remaining FIFO entries still drain.
- **fetch_en deassert mid-stream:** current-cycle push suppressed, pc held. Resumes from the same pc.
- **Reset mid-operation:** immediate return to reset values regardless of state or FIFO occupancy.
- **Outputs when FIFO empty:** if_instr and if_pc hold their last value; they are don't-care to decode but must not be X after reset.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_state_t {IDLE, RUN, HALT};
  - localparams for IMEM_TYPE_SINGLE = 2'b00 and HALT_WORD default;
  - typedef fetch_entry_t packed struct {pc, instr}.
- One natural sub-module, fetch_fifo: parameterized DEPTH, entry type fetch_entry_t, with push, pop, flush, count, and head outputs. flush has priority over push.
- The FSM and PC logic live in fetch_sequencer.

Test Plan:
- Reset, fetch_en = 1, if_ready = 1, ROM[0..3] = A,B,C,D -> if_valid rises cycle 2; if_pc 0,1,2,3 and if_instr A,B,C,D on consecutive cycles; imem_opcode_type always 2'b00.
- Backpressure: if_ready = 0 for 5 cycles -> FIFO fills to 2, imem_addr stalls at 2, if_pc stays 0. Release -> 0,1,2,... with no loss or duplicate.
- Redirect to 16'h0100 while FIFO is full and if_ready = 1 -> next cycle if_valid = 0; the following delivered if_pc = 16'h0100; no stale entries.
- Wrap: redirect to 16'hFFFE -> delivered if_pc sequence FFFE, FFFF, 0000, 0001.
- ROM[5] = HALT_WORD -> words 0..5 delivered, halted = 1, imem_addr frozen at 6. A later redirect to 16'h0010 clears halted and delivers from 16'h0010.
- Async reset asserted mid-stream between clock edges -> if_valid, halted, and count go 0 immediately; imem_addr = RESET_PC.
